lfsr_checker: RTL and testbench

Receive-side companion to the 16-bit PRBS generator: consumes the generator's tagged 32-bit frame stream, validates framing, and recovers the 16-bit state. Self-synchronises a local copy of the same LFSR (polynomial taps 16,14,13,11, right shift) and counts word and bit errors once locked. Sits at the far end of the test link on the DE2-115 board; its status outputs drive LEDs and 7-segment displays.

---
 rtl/lfsr_checker.sv | 156 +++++++++++++++
 tb/tb_lfsr_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side PRBS-16 checker: validates tagged frames, self-synchronises a local
// LFSR copy (taps 16,14,13,11, right shift) and counts word/bit/frame errors.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             data_valid,
  input  logic [31:0]      data_in,
  output logic [15:0]      rx_q,
  output logic             locked,
  output logic             word_ok,
  output logic             word_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_err_count,
  output logic [CNT_W-1:0] frame_err_count
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SW = CNT_W + 5;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t            state;
  logic [15:0]       exp;
  logic [MW-1:0]     match_cnt;
  logic [UW-1:0]     miss_cnt;

  logic [15:0]       rx;
  logic              well_formed;
  logic              accept;
  logic              bad;
  logic [15:0]       rx_next;
  logic [15:0]       exp_next;
  logic [4:0]        pop;
  logic [MW-1:0]     match_inc;
  logic [UW-1:0]     miss_inc;
  logic [CNT_W-1:0]  err_inc;
  logic [CNT_W-1:0]  fe_inc;
  logic [SW-1:0]     bit_sum;
  logic [CNT_W-1:0]  bit_inc;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[13] ^ s[15] ^ s[12] ^ s[10], s[15:1]};
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Frame unpacking, tag validation and saturating counter increments.
  always_comb begin
    rx          = {data_in[25:24], data_in[20:16], data_in[12:8], data_in[4:1]};
    well_formed = (data_in[31:26] == 6'b011000) && (data_in[23:21] == 3'b010) &&
                  (data_in[15:13] == 3'b001) && (data_in[7:5] == 3'b000) && data_in[0];
    accept      = data_valid && well_formed;
    bad         = data_valid && !well_formed;
    rx_next     = lfsr_next(rx);
    exp_next    = lfsr_next(exp);
    pop         = popcnt(rx ^ exp);
    match_inc   = match_cnt + MW'(1);
    miss_inc    = miss_cnt + UW'(1);
    err_inc     = (err_count == '1) ? err_count : err_count + CNT_W'(1);
    fe_inc      = (frame_err_count == '1) ? frame_err_count : frame_err_count + CNT_W'(1);
    bit_sum     = SW'(bit_err_count) + SW'(pop);
    bit_inc     = (bit_sum > SW'({CNT_W{1'b1}})) ? '1 : bit_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state           <= HUNT;
      exp             <= '0;
      match_cnt       <= '0;
      miss_cnt        <= '0;
      rx_q            <= '0;
      locked          <= 1'b0;
      word_ok         <= 1'b0;
      word_err        <= 1'b0;
      frame_err       <= 1'b0;
      err_count       <= '0;
      bit_err_count   <= '0;
      frame_err_count <= '0;
    end else begin
      word_ok   <= 1'b0;
      word_err  <= 1'b0;
      frame_err <= 1'b0;
      if (bad) begin
        frame_err       <= 1'b1;
        frame_err_count <= fe_inc;
      end else if (accept) begin
        rx_q <= rx;
        case (state)
          HUNT: begin
            // All-zero is the LFSR lock-up state and can never seed a valid sequence.
            if (rx != 16'h0000) begin
              exp       <= rx_next;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (rx == exp) begin
              word_ok <= 1'b1;
              exp     <= rx_next;
              if (match_inc == MW'(LOCK_CNT)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_inc;
              end
            end else if (rx == 16'h0000) begin
              state     <= HUNT;
              match_cnt <= '0;
            end else begin
              exp       <= rx_next;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run the local copy so isolated corruption does not re-seed it.
            exp <= exp_next;
            if (rx == exp) begin
              word_ok  <= 1'b1;
              miss_cnt <= '0;
            end else begin
              word_err      <= 1'b1;
              err_count     <= err_inc;
              bit_err_count <= bit_inc;
              if (miss_inc == UW'(UNLOCK_CNT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker against a behavioural model;
// a second instance with 4-bit counters exercises saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;

  logic [15:0] rx_q, err_count, bit_err_count, frame_err_count;
  logic        locked, word_ok, word_err, frame_err;
  logic [15:0] s_rx_q;
  logic        s_locked, s_word_ok, s_word_err, s_frame_err;
  logic [3:0]  s_err_count, s_bit_err_count, s_frame_err_count;

  int n_checks = 0;
  int n_fail = 0;

  lfsr_checker dut (
    .clk(clk), .clr_n(clr_n), .data_valid(data_valid), .data_in(data_in),
    .rx_q(rx_q), .locked(locked), .word_ok(word_ok), .word_err(word_err),
    .frame_err(frame_err), .err_count(err_count), .bit_err_count(bit_err_count),
    .frame_err_count(frame_err_count)
  );

  lfsr_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .clr_n(clr_n), .data_valid(data_valid), .data_in(data_in),
    .rx_q(s_rx_q), .locked(s_locked), .word_ok(s_word_ok), .word_err(s_word_err),
    .frame_err(s_frame_err), .err_count(s_err_count), .bit_err_count(s_bit_err_count),
    .frame_err_count(s_frame_err_count)
  );

  always #5 clk = ~clk;

  // Reference model: frame semantics and sync behaviour from the rules, plain arithmetic.
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  int          m_mode, m_streak, m_misses;
  int          tot_err, tot_bits, tot_frame;
  logic [15:0] m_exp, m_rx_q;
  bit          m_ok, m_err, m_ferr;
  logic [15:0] gen;

  function automatic logic [15:0] prbs_step(input logic [15:0] s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return 16'((s >> 1) | (fb << 15));
  endfunction

  function automatic logic [31:0] pack(input logic [15:0] q);
    return 32'h6040_2001 | (32'((q >> 14) & 3) << 24) | (32'((q >> 9) & 31) << 16) |
           (32'((q >> 4) & 31) << 8) | (32'(q & 15) << 1);
  endfunction

  function automatic logic [15:0] unpack(input logic [31:0] d);
    return 16'((((d >> 24) & 3) << 14) | (((d >> 16) & 31) << 9) |
               (((d >> 8) & 31) << 4) | ((d >> 1) & 15));
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_streak = 0; m_misses = 0; m_exp = '0; m_rx_q = '0;
    tot_err = 0; tot_bits = 0; tot_frame = 0;
    m_ok = 0; m_err = 0; m_ferr = 0;
  endtask

  task automatic model_update(input logic c, input logic v, input logic [31:0] d);
    logic [15:0] r;
    if (!c) begin
      model_reset();
      return;
    end
    m_ok = 0; m_err = 0; m_ferr = 0;
    if (!v) return;
    if ((d & 32'hFCE0_E0E1) != 32'h6040_2001) begin
      m_ferr = 1; tot_frame++;
      return;
    end
    r = unpack(d);
    m_rx_q = r;
    if (m_mode == M_HUNT) begin
      if (r != 0) begin m_exp = prbs_step(r); m_streak = 0; m_mode = M_VERIFY; end
    end else if (m_mode == M_VERIFY) begin
      if (r == m_exp) begin
        m_ok = 1; m_exp = prbs_step(r); m_streak++;
        if (m_streak == 4) begin m_mode = M_LOCKED; m_misses = 0; end
      end else if (r == 0) begin
        m_mode = M_HUNT; m_streak = 0;
      end else begin
        m_exp = prbs_step(r); m_streak = 0;
      end
    end else begin
      if (r == m_exp) begin
        m_ok = 1; m_misses = 0;
      end else begin
        m_err = 1; tot_err++; tot_bits += $countones(r ^ m_exp); m_misses++;
        if (m_misses == 3) begin m_mode = M_HUNT; m_misses = 0; m_streak = 0; end
      end
      m_exp = prbs_step(m_exp);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_mode == M_LOCKED));
    check("word_ok", 32'(word_ok), 32'(m_ok));
    check("word_err", 32'(word_err), 32'(m_err));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("rx_q", 32'(rx_q), 32'(m_rx_q));
    check("err_count", 32'(err_count), 32'(sat(tot_err, 65535)));
    check("bit_err_count", 32'(bit_err_count), 32'(sat(tot_bits, 65535)));
    check("frame_err_count", 32'(frame_err_count), 32'(sat(tot_frame, 65535)));
    check("s_locked", 32'(s_locked), 32'(m_mode == M_LOCKED));
    check("s_err_count", 32'(s_err_count), 32'(sat(tot_err, 15)));
    check("s_bit_err_count", 32'(s_bit_err_count), 32'(sat(tot_bits, 15)));
    check("s_frame_err_count", 32'(s_frame_err_count), 32'(sat(tot_frame, 15)));
  endtask

  task automatic step(input logic c, input logic v, input logic [31:0] d);
    @(negedge clk);
    clr_n = c; data_valid = v; data_in = d;
    @(posedge clk);
    model_update(c, v, d);
    #1;
    compare_all();
  endtask

  task automatic send_clean();
    step(1'b1, 1'b1, pack(gen));
    gen = prbs_step(gen);
  endtask

  initial begin
    logic [31:0] w;
    model_reset();
    step(1'b0, 1'b1, 32'h62562E03);
    step(1'b0, 1'b0, '0);
    check("reset_rx_q", 32'(rx_q), 32'h0);

    // Clean stream seeded at 16'hACE1.
    gen = 16'hACE1;
    w = pack(gen);
    check("first_frame", w, 32'h62562E03);
    check("next_state", 32'(prbs_step(gen)), 32'h0000D670);
    for (int i = 1; i <= 8; i++) begin
      send_clean();
      if (i == 1) check("no_ok_f1", 32'(word_ok), 32'h0);
      if (i == 4) check("unlocked_f4", 32'(locked), 32'h0);
      if (i == 5) check("locked_f5", 32'(locked), 32'h1);
    end

    // Single flipped payload bit while locked.
    step(1'b1, 1'b1, pack(gen) ^ 32'h0010_0000);
    gen = prbs_step(gen);
    check("flip_bits", 32'(bit_err_count), 32'h1);
    send_clean();
    check("flip_recover_ok", 32'(word_ok), 32'h1);

    // Corrupted tag: frame error only, stream alignment retained.
    step(1'b1, 1'b1, pack(gen) & 32'h00FF_FFFF);
    check("tag_ferr_cnt", 32'(frame_err_count), 32'h1);
    send_clean();
    check("tag_next_ok", 32'(word_ok), 32'h1);

    // Three random frames drop lock; clean stream relocks after five.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, pack(16'($urandom)));
      gen = prbs_step(gen);
    end
    check("unlock_after_3", 32'(locked), 32'h0);
    for (int i = 1; i <= 5; i++) send_clean();
    check("relock", 32'(locked), 32'h1);

    // Idle cycles and reset mid-lock.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, pack(gen));
    check("reset_drops_lock", 32'(locked), 32'h0);

    // Lock-up state frames are ignored in HUNT.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, pack(16'h0000));
    check("zero_hunt_ok", 32'(word_ok), 32'h0);

    // Saturation of the narrow instance's frame error counter.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h0);
    check("sat_frame", 32'(s_frame_err_count), 32'hF);

    // Randomised mix.
    gen = 16'(($urandom & 16'hFFFE) | 1);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) send_clean();
      else if (r == 10) begin step(1'b1, 1'b1, pack(gen) ^ (32'h1 << $urandom_range(0, 31))); gen = prbs_step(gen); end
      else if (r == 11) begin step(1'b1, 1'b1, pack(gen) ^ (32'($urandom) & 32'h031F1F1E)); gen = prbs_step(gen); end
      else if (r == 12) step(1'b1, 1'b1, pack(gen) ^ 32'h8000_0000);
      else if (r == 13) step(1'b1, 1'b0, $urandom);
      else if (r == 14) begin step(1'b1, 1'b1, pack(16'($urandom))); gen = prbs_step(gen); end
      else if (r == 15) step(1'b1, 1'b1, $urandom);
      else if (r == 16 && $urandom_range(0, 15) == 0) step(1'b0, 1'b1, pack(gen));
      else send_clean();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
